// File: rtl/fifo_element.sv
// Single storage stage of a shift-register FIFO: one data word plus a full flag.
// Chained prev -> this -> next; the accept term ripples back combinationally from the consumer.
module fifo_element #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] DATA_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             prev_full,
  input  logic [WIDTH-1:0] prev_data,
  output logic             prev_accept,
  input  logic             next_accept,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;
  logic             w_accept;

  // A stage can take a new word when it is empty or its word leaves this edge.
  assign w_accept = clear ? 1'b0 : (!r_full || next_accept);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full <= 1'b0;
      r_data <= DATA_RESET;
    end else if (clear) begin
      r_full <= 1'b0;
      r_data <= DATA_RESET;
    end else if (w_accept) begin
      r_full <= prev_full;
      r_data <= prev_full ? prev_data : DATA_RESET;
    end
  end

  assign prev_accept = w_accept;
  assign full        = r_full;
  assign data        = r_data;

endmodule

// File: tb/tb_fifo_element.sv
// Self-checking bench for fifo_element: directed cases followed by randomized
// traffic compared against a word-level model of one FIFO slot.
module tb_fifo_element;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       prev_full;
  logic [7:0] prev_data;
  logic       prev_accept;
  logic       next_accept;
  logic       full;
  logic [7:0] data;

  int testsRun;
  int testsFailed;

  // Reference slot: either holds a word or is empty.
  bit       mHasWord;
  bit [7:0] mWord;

  fifo_element #(.WIDTH(8), .DATA_RESET(8'h00)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .prev_full  (prev_full),
    .prev_data  (prev_data),
    .prev_accept(prev_accept),
    .next_accept(next_accept),
    .full       (full),
    .data       (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit c, input bit pf, input bit [7:0] pd, input bit na);
    clear       = c;
    prev_full   = pf;
    prev_data   = pd;
    next_accept = na;
  endtask

  // One clock of traffic: check the accept term, clock, advance the model, check the slot.
  task automatic step(input string tag, input bit c, input bit pf, input bit [7:0] pd, input bit na);
    bit takes;
    applyStimulus(c, pf, pd, na);
    #1;
    takes = !c && (!mHasWord || na);
    checkOutput({tag, ".prev_accept"}, 32'(prev_accept), 32'(takes));
    @(posedge clk);
    if (c) begin
      mHasWord = 1'b0;
      mWord    = 8'h00;
    end else if (takes) begin
      mHasWord = pf;
      mWord    = pf ? pd : 8'h00;
    end
    #1;
    checkOutput({tag, ".full"}, 32'(full), 32'(mHasWord));
    checkOutput({tag, ".data"}, 32'(data), 32'(mWord));
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    mHasWord    = 1'b0;
    mWord       = 8'h00;
    reset       = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    #2;
    checkOutput("reset.full", 32'(full), 32'd0);
    checkOutput("reset.data", 32'(data), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Store while successor is busy
    step("load", 1'b0, 1'b1, 8'hA5, 1'b0);
    checkOutput("load.lit", 32'(data), 32'hA5);
    for (int i = 0; i < 4; i++) begin
      step("store", 1'b0, 1'b1, 8'h3C, 1'b0);
      checkOutput("store.lit", 32'(data), 32'hA5);
    end

    // Pass on while the predecessor has a word
    step("pass", 1'b0, 1'b1, 8'h3C, 1'b1);
    checkOutput("pass.lit", 32'(data), 32'h3C);

    // Empty when the predecessor has nothing
    step("reload", 1'b0, 1'b1, 8'hA5, 1'b1);
    step("drain", 1'b0, 1'b0, 8'h77, 1'b1);
    checkOutput("drain.lit", 32'({full, data}), 32'h000);

    // Empty stage accepts even with a stalled successor
    step("copy", 1'b0, 1'b1, 8'h5A, 1'b0);
    checkOutput("copy.lit", 32'({full, data}), 32'h15A);

    // Asynchronous reset between clock edges
    step("load2", 1'b0, 1'b1, 8'hA5, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async.full", 32'(full), 32'd0);
    checkOutput("async.data", 32'(data), 32'd0);
    mHasWord = 1'b0;
    mWord    = 8'h00;
    #1;
    reset = 1'b0;
    step("after_reset", 1'b0, 1'b1, 8'h11, 1'b0);
    checkOutput("after_reset.lit", 32'(data), 32'h11);

    // Clear beats an incoming word
    step("load3", 1'b0, 1'b1, 8'hA5, 1'b1);
    step("clear", 1'b1, 1'b1, 8'h3C, 1'b1);
    checkOutput("clear.lit", 32'({full, data}), 32'h000);

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 15) == 0), 1'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
